// File: rtl/cal_acc_bias_leaky_int16_pkg.sv
// Shared constants and config record for the conv output stage
// (accumulate, bias, rescale, leaky ReLU, int16 saturation).
package cal_acc_bias_leaky_int16_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int LEAKY_MUL = 13;
  localparam int LEAKY_SHR = 7;
  localparam int INT16_MAX = 32767;
  localparam int INT16_MIN = -32768;

  // Per-group rescale/activation config that travels with the data.
  typedef struct packed {
    logic [4:0] shift;
    logic       leaky_en;
  } post_cfg_t;

endpackage

// File: rtl/cal_acc_bias_leaky_int16_if.sv
// Bus between the adder tree / config source and the output stage.
// Handshake: valid-only streaming, no ready. din is consumed in every cycle
// with din_valid=1 (unless clear=1); dout is meaningful only in the single
// cycle dout_valid=1 and the consumer must always accept it.
interface cal_acc_bias_leaky_int16_if #(
  parameter int CH_W = 10
);
  logic                   din_valid;
  logic signed [17:0]     din;
  logic signed [15:0]     bias;
  logic        [CH_W-1:0] cfg_ch_num;
  logic        [4:0]      cfg_shift;
  logic                   cfg_leaky_en;
  logic                   clear;
  logic                   dout_valid;
  logic signed [15:0]     dout;
  logic                   busy;

  modport master (
    output din_valid, din, bias, cfg_ch_num, cfg_shift, cfg_leaky_en, clear,
    input  dout_valid, dout, busy
  );

  modport slave (
    input  din_valid, din, bias, cfg_ch_num, cfg_shift, cfg_leaky_en, clear,
    output dout_valid, dout, busy
  );
endinterface

// File: rtl/cal_leaky_sat_int16.sv
// Combinational leaky ReLU (x*13 >>> 7, floor) followed by int16 saturation.
module cal_leaky_sat_int16
  import cal_acc_bias_leaky_int16_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] r_i,
  input  logic                    leaky_en_i,
  output logic signed [15:0]      y_o
);
  // Four guard bits keep r*13 exact for any ACC_W-bit input.
  localparam int XW = ACC_W + 4;
  localparam logic signed [XW-1:0] MUL_X = XW'(LEAKY_MUL);
  localparam logic signed [XW-1:0] MAX_X = XW'(INT16_MAX);
  localparam logic signed [XW-1:0] MIN_X = XW'(INT16_MIN);

  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] prod_x;
  logic signed [XW-1:0] y_x;

  // Negative values are scaled when leaky is enabled, then clamped to int16.
  always_comb begin
    r_x    = XW'(r_i);
    prod_x = r_x * MUL_X;
    if (leaky_en_i && r_x[XW-1]) y_x = prod_x >>> LEAKY_SHR;
    else                         y_x = r_x;
    if (y_x > MAX_X)      y_o = MAX_X[15:0];
    else if (y_x < MIN_X) y_o = MIN_X[15:0];
    else                  y_o = y_x[15:0];
  end
endmodule

// File: rtl/cal_acc_bias_leaky_int16.sv
// Conv output stage: accumulates N adder-tree sums plus bias, then a
// three-register pipeline S1 (final sum) -> S2 (rounded shift) -> S3 (dout).
module cal_acc_bias_leaky_int16
  import cal_acc_bias_leaky_int16_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CH_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cal_acc_bias_leaky_int16_if.slave    bus
);
  logic        [CH_W-1:0]  ch_cnt_q, ch_cnt_d, n_q, n_d, n_cfg, n_cur;
  logic signed [ACC_W-1:0] acc_q, acc_d, din_ext, bias_ext, first_sum, acc_sum;
  post_cfg_t               cfg_q, cfg_d, cfg_in;
  logic                    first, last;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;
  post_cfg_t               s1_cfg_q, s1_cfg_d;

  logic                    s2_valid_q;
  logic signed [ACC_W-1:0] s2_r_q, s2_r_d, s2_rnd;
  logic                    s2_leaky_q;

  logic                    dout_valid_q;
  logic signed [15:0]      dout_q, s3_y;

  // Beat counting, accumulation and hand-off of the final sum into S1.
  always_comb begin
    din_ext   = {{(ACC_W-18){bus.din[17]}}, bus.din};
    bias_ext  = {{(ACC_W-16){bus.bias[15]}}, bus.bias};
    first_sum = din_ext + bias_ext;
    acc_sum   = acc_q + din_ext;
    cfg_in    = '{shift: bus.cfg_shift, leaky_en: bus.cfg_leaky_en};
    n_cfg     = (bus.cfg_ch_num == '0) ? CH_W'(1) : bus.cfg_ch_num;
    first     = (ch_cnt_q == '0);
    n_cur     = first ? n_cfg : n_q;
    last      = (ch_cnt_q == n_cur - CH_W'(1));

    ch_cnt_d   = ch_cnt_q;
    acc_d      = acc_q;
    n_d        = n_q;
    cfg_d      = cfg_q;
    s1_valid_d = 1'b0;
    s1_sum_d   = s1_sum_q;
    s1_cfg_d   = s1_cfg_q;

    if (bus.clear) begin
      ch_cnt_d = '0;
      acc_d    = '0;
    end else if (bus.din_valid) begin
      if (first) begin
        acc_d = first_sum;
        n_d   = n_cfg;
        cfg_d = cfg_in;
      end else begin
        acc_d = acc_sum;
      end
      if (last) begin
        ch_cnt_d   = '0;
        s1_valid_d = 1'b1;
        s1_sum_d   = first ? first_sum : acc_sum;
        s1_cfg_d   = first ? cfg_in : cfg_q;
      end else begin
        ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
    end
  end

  // Round half up: add 2^(shift-1) (zero when shift is 0), then arithmetic shift.
  always_comb begin
    s2_rnd = (ACC_W'(1) << s1_cfg_q.shift) >> 1;
    s2_r_d = (s1_sum_q + s2_rnd) >>> s1_cfg_q.shift;
  end

  cal_leaky_sat_int16 #(.ACC_W(ACC_W)) u_leaky_sat (
    .r_i        (s2_r_q),
    .leaky_en_i (s2_leaky_q),
    .y_o        (s3_y)
  );

  // Group state registers: counter, accumulator, latched group config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt_q <= '0;
      acc_q    <= '0;
      n_q      <= CH_W'(1);
      cfg_q    <= '0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      acc_q    <= acc_d;
      n_q      <= n_d;
      cfg_q    <= cfg_d;
    end
  end

  // Pipeline registers S1..S3; each stage carries its own valid and config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_cfg_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_r_q       <= '0;
      s2_leaky_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sum_q     <= s1_sum_d;
      s1_cfg_q     <= s1_cfg_d;
      s2_valid_q   <= s1_valid_q;
      s2_r_q       <= s2_r_d;
      s2_leaky_q   <= s1_cfg_q.leaky_en;
      dout_valid_q <= s2_valid_q;
      if (s2_valid_q) dout_q <= s3_y;
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.busy       = (ch_cnt_q != '0);
endmodule
